// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder modelling the LSU data SRAM: independent read/write channels,
// fixed or LFSR-driven latency, byte-strobed commits. Ports mirror the slave modport of axi4_lite_interface.
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH      = 1024,
    parameter bit          RANDOM_LAT = 1'b0,
    parameter int          RD_LAT     = 1,
    parameter int          WR_LAT     = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, B_RESP} w_state_t;

    function automatic logic in_range(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];

    // latency source
    logic [7:0] lfsr;
    logic [7:0] lfsr_dly, rd_dly, wr_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign lfsr_dly = {6'd0, lfsr[1:0]} + 8'd1;
    assign rd_dly   = RANDOM_LAT ? lfsr_dly : 8'(RD_LAT);
    assign wr_dly   = RANDOM_LAT ? lfsr_dly : 8'(WR_LAT);

    // read channel
    r_state_t    r_state, r_nxt;
    logic [7:0]  r_cnt, r_cnt_nxt;
    logic [31:0] r_addr;
    logic        ar_rdy, r_vld, ar_fire, r_load;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    assign ar_fire = arvalid & ar_rdy;

    always_comb begin
        r_nxt     = r_state;
        r_cnt_nxt = r_cnt;
        r_load    = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_fire) begin
                r_nxt     = R_WAIT;
                r_cnt_nxt = rd_dly;
            end
            R_WAIT: if (r_cnt == 8'd1) begin
                r_load = 1'b1;
                r_nxt  = R_RESP;
            end else begin
                r_cnt_nxt = r_cnt - 8'd1;
            end
            R_RESP: if (rready) r_nxt = R_IDLE;
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            ar_rdy  <= 1'b0;
            r_vld   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            r_state <= r_nxt;
            r_cnt   <= r_cnt_nxt;
            ar_rdy  <= (r_nxt == R_IDLE);
            r_vld   <= (r_nxt == R_RESP);
            if (ar_fire) r_addr <= araddr;
            // loads on the same edge as a colliding commit, so it sees pre-write data
            if (r_load) begin
                rdata_q <= in_range(r_addr) ? mem[word_idx(r_addr)] : '0;
                rresp_q <= in_range(r_addr) ? 2'b00 : 2'b10;
            end
        end
    end

    // write channel
    w_state_t    w_state, w_nxt;
    logic [7:0]  w_cnt, w_cnt_nxt;
    logic        aw_got, w_got, aw_got_nxt, w_got_nxt, aw_have, w_have;
    logic        aw_rdy, w_rdy, b_vld, aw_fire, w_fire, commit;
    logic [31:0] w_addr, w_data;
    logic [3:0]  w_strb;
    logic [1:0]  bresp_q;

    assign aw_fire = awvalid & aw_rdy;
    assign w_fire  = wvalid & w_rdy;
    assign aw_have = aw_got | aw_fire;
    assign w_have  = w_got | w_fire;

    always_comb begin
        w_nxt      = w_state;
        w_cnt_nxt  = w_cnt;
        aw_got_nxt = aw_got;
        w_got_nxt  = w_got;
        commit     = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_got_nxt = aw_have;
                w_got_nxt  = w_have;
                if (aw_have && w_have) begin
                    w_nxt      = W_WAIT;
                    w_cnt_nxt  = wr_dly;
                    aw_got_nxt = 1'b0;
                    w_got_nxt  = 1'b0;
                end
            end
            W_WAIT: if (w_cnt == 8'd1) begin
                commit = 1'b1;
                w_nxt  = B_RESP;
            end else begin
                w_cnt_nxt = w_cnt - 8'd1;
            end
            B_RESP: if (bready) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_rdy  <= 1'b0;
            w_rdy   <= 1'b0;
            b_vld   <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= '0;
        end else begin
            w_state <= w_nxt;
            w_cnt   <= w_cnt_nxt;
            aw_got  <= aw_got_nxt;
            w_got   <= w_got_nxt;
            aw_rdy  <= (w_nxt == W_IDLE) && !aw_got_nxt;
            w_rdy   <= (w_nxt == W_IDLE) && !w_got_nxt;
            b_vld   <= (w_nxt == B_RESP);
            if (aw_fire) w_addr <= awaddr;
            if (w_fire) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (commit) bresp_q <= in_range(w_addr) ? 2'b00 : 2'b10;
        end
    end

    // no reset on the array; commit is only possible out of reset
    always_ff @(posedge clk) begin
        if (commit && in_range(w_addr)) begin
            for (int i = 0; i < 4; i++)
                if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
        end
    end

    assign arready = ar_rdy;
    assign rvalid  = r_vld;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = aw_rdy;
    assign wready  = w_rdy;
    assign bvalid  = b_vld;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Randomized bench for axi_lite_sram_slave: a fixed-latency and a random-latency instance
// share one stimulus bus (sel picks which one sees valids) and are checked against a word-array model.
module tb_axi_lite_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          WIN   = 16;
    localparam int          LIM   = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic [31:0] f_rdata, r_rdata;
    logic [1:0]  f_rresp, r_rresp, f_bresp, r_bresp;
    logic        f_arready, r_arready, f_rvalid, r_rvalid;
    logic        f_awready, r_awready, f_wready, r_wready, f_bvalid, r_bvalid;

    wire [31:0] rdata   = sel ? r_rdata   : f_rdata;
    wire [1:0]  rresp   = sel ? r_rresp   : f_rresp;
    wire [1:0]  bresp   = sel ? r_bresp   : f_bresp;
    wire        arready = sel ? r_arready : f_arready;
    wire        rvalid  = sel ? r_rvalid  : f_rvalid;
    wire        awready = sel ? r_awready : f_awready;
    wire        wready  = sel ? r_wready  : f_wready;
    wire        bvalid  = sel ? r_bvalid  : f_bvalid;

    axi_lite_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .RANDOM_LAT(1'b0), .RD_LAT(1), .WR_LAT(1)) u_fix (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & ~sel), .arready(f_arready),
        .rdata(f_rdata), .rresp(f_rresp), .rvalid(f_rvalid), .rready(rready & ~sel),
        .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(f_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel), .wready(f_wready),
        .bresp(f_bresp), .bvalid(f_bvalid), .bready(bready & ~sel));

    axi_lite_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .RANDOM_LAT(1'b1)) u_rnd (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & sel), .arready(r_arready),
        .rdata(r_rdata), .rresp(r_rresp), .rvalid(r_rvalid), .rready(rready & sel),
        .awaddr(awaddr), .awvalid(awvalid & sel), .awready(r_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(r_wready),
        .bresp(r_bresp), .bvalid(r_bvalid), .bready(bready & sel));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // model: current value, value before the last commit, and the edge of that commit
    logic [31:0] mval  [2][DEPTH];
    logic [31:0] mprev [2][DEPTH];
    int          mcyc  [2][DEPTH];

    function automatic bit in_rng(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic chk_lat(input string tag, input int lat);
        if (sel) chk({tag, "_rng"}, 32'(lat >= 1 && lat <= 4), 1);
        else     chk(tag, lat, 1);
    endtask

    task automatic rd_txn(input logic [31:0] a, input int hold);
        int t, hs, lat, s, ix;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        s = int'(sel);
        araddr = a; arvalid = 1'b1; t = 0;
        while (!arready && t < LIM) begin @(negedge clk); t++; end
        if (t >= LIM) chk("ar_timeout", t, 0);
        hs = cyc + 1;
        @(negedge clk); arvalid = 1'b0; t = 0;
        while (!rvalid && t < LIM) begin @(negedge clk); t++; end
        lat = cyc - hs;
        chk_lat("r_lat", lat);
        if (in_rng(a)) begin
            ix = idx_of(a);
            exp_d = (mcyc[s][ix] == cyc) ? mprev[s][ix] : mval[s][ix];
            exp_r = 2'b00;
        end else begin
            exp_d = '0;
            exp_r = 2'b10;
        end
        chk("rdata", rdata, exp_d);
        chk("rresp", 32'(rresp), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_vld", 32'(rvalid), 1);
            chk("r_hold_data", rdata, exp_d);
            chk("r_hold_arready", 32'(arready), 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("arready_again", 32'(arready), 1);
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly, input int hold);
        int t, k, hs, lat, s, ix;
        bit awp, wp;
        logic [1:0] exp_r;
        s = int'(sel);
        awp = 1'b1; wp = 1'b1; t = 0; k = 0; hs = 0;
        awaddr = a; wdata = d; wstrb = st;
        while ((awp || wp) && t < LIM) begin
            awvalid = awp && (k >= aw_dly);
            wvalid  = wp && (k >= w_dly);
            if (awvalid && awready) awp = 1'b0;
            if (wvalid && wready)   wp  = 1'b0;
            if (!awp && !wp) hs = cyc + 1;
            @(negedge clk); k++; t++;
            if (!wp && awp) chk("wready_drop", 32'(wready), 0);
            if (!awp && wp) chk("awready_drop", 32'(awready), 0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (t >= LIM) chk("aw_w_timeout", t, 0);
        t = 0;
        while (!bvalid && t < LIM) begin @(negedge clk); t++; end
        lat = cyc - hs;
        chk_lat("b_lat", lat);
        if (in_rng(a)) begin
            ix = idx_of(a);
            mprev[s][ix] = mval[s][ix];
            mval[s][ix]  = merge(mval[s][ix], d, st);
            mcyc[s][ix]  = cyc;
            exp_r = 2'b00;
        end else begin
            exp_r = 2'b10;
        end
        chk("bresp", 32'(bresp), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("b_hold_vld", 32'(bvalid), 1);
            chk("b_hold_resp", 32'(bresp), 32'(exp_r));
            chk("b_hold_rdy", 32'({awready, wready}), 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("w_rdy_again", 32'({awready, wready}), 32'h3);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return BASE - 32'd4;
        if (r == 1) return BASE + 32'(4 * DEPTH);
        return BASE + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {rdata, 14'd0, rresp, bresp, arready, rvalid, awready, wready, bvalid}, 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) begin
                mval[s][i] = '0; mprev[s][i] = '0; mcyc[s][i] = -1;
            end

        // reset state and first cycle out of reset
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk_all_zero("reset_outputs");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk("ready_after_reset", {29'd0, arready, awready, wready}, 32'h7);
        end

        // fixed latency directed cases
        sel = 1'b0;
        @(negedge clk);
        wr_txn(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        rd_txn(BASE + 32'h10, 0);
        wr_txn(BASE + 32'h10, 32'h1122_3344, 4'b0101, 0, 0, 0);
        rd_txn(BASE + 32'h10, 0);
        wr_txn(BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 3, 0, 5);
        rd_txn(BASE + 32'h20, 4);
        rd_txn(32'h7FFF_FFFC, 0);
        wr_txn(BASE, 32'h0BAD_0001, 4'hF, 0, 2, 0);
        wr_txn(BASE + 32'hFFC, 32'h5A5A_A5A5, 4'hF, 0, 0, 0);
        rd_txn(BASE + 32'hFFC, 0);
        wr_txn(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
        rd_txn(BASE, 0);
        rd_txn(BASE + 32'h10, 0);
        rd_txn(BASE + 32'hFFC, 1);

        // random latency, concurrent channels on a small window to force collisions
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < WIN; i++) wr_txn(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
        fork
            begin
                logic [31:0] ra;
                for (int i = 0; i < 500; i++) begin
                    ra = pick_addr();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rd_txn(ra, int'($urandom_range(0, 2)));
                end
            end
            begin
                logic [31:0] wa;
                for (int j = 0; j < 500; j++) begin
                    wa = pick_addr();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    wr_txn(wa, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
                end
            end
        join

        // reset during W_WAIT abandons the write
        @(negedge clk);
        awaddr = BASE + 32'hC; wdata = ~mval[1][3]; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        chk("mid_rdy", {30'd0, awready, wready}, 32'h3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset_outputs");
        repeat (2) @(negedge clk);
        chk_all_zero("mid_reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", {29'd0, arready, awready, wready}, 32'h7);
        repeat (3) begin
            @(negedge clk);
            chk("no_late_bvalid", 32'(bvalid), 0);
        end
        rd_txn(BASE + 32'hC, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: cycle %0d reached, checks %0d/%0d", cyc, n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
